// File: rtl/sgnmag_conv_pipe_if.sv
// Valid/ready stream bundle for sgnmag_conv_pipe: input side (in_*) and output side (out_*).
// The optional exception counter is a plain port on the converter (SGNMAG_EXCP_CNT_EN).
interface sgnmag_conv_pipe_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         out_excp;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_excp
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_excp
    );
endinterface

// File: rtl/sgnmag_conv_pipe.sv
// Pipelined two's-complement <-> sign-magnitude converter with valid/ready flow control.
// Define SGNMAG_EXCP_CNT_EN to add the saturating exception counter port excp_cnt.
module sgnmag_conv_pipe #(
    parameter int W     = 12,
    parameter int PIPE  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sgnmag_conv_pipe_if.slave s
`ifdef SGNMAG_EXCP_CNT_EN
    ,
    output logic [CNT_W-1:0] excp_cnt
`endif
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         out_mode_q;
    logic         out_excp_q;

    logic         adv_out;
    logic         c_valid;
    logic [W-1:0] c_data;
    logic         c_mode;

    assign adv_out = s.out_ready | ~out_valid_q;

    generate
        if (PIPE == 2) begin : g_two_stage
            logic         s1_valid_q;
            logic [W-1:0] s1_data_q;
            logic         s1_mode_q;
            logic         adv_s1;

            // Stage 1 may fill a hole even while the output register is stalled.
            assign adv_s1 = adv_out | ~s1_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_mode_q  <= 1'b0;
                end else if (adv_s1) begin
                    s1_valid_q <= s.in_valid;
                    s1_data_q  <= s.in_data;
                    s1_mode_q  <= s.in_mode;
                end
            end

            assign s.in_ready = adv_s1;
            assign c_valid    = s1_valid_q;
            assign c_data     = s1_data_q;
            assign c_mode     = s1_mode_q;
        end else begin : g_one_stage
            assign s.in_ready = adv_out;
            assign c_valid    = s.in_valid;
            assign c_data     = s.in_data;
            assign c_mode     = s.in_mode;
        end
    endgenerate

    logic [W-2:0] mag;
    logic [W-1:0] neg_mag;
    logic [W-1:0] conv_data_d;
    logic         conv_excp_d;

    // -{0,m} shares its low bits with -x for negative x, so one negator serves both modes.
    assign mag     = c_data[W-2:0];
    assign neg_mag = ~{1'b0, mag} + 1'b1;

    always_comb begin
        conv_data_d = c_data;
        conv_excp_d = 1'b0;
        if (c_data[W-1]) begin
            if (mag == '0) begin
                conv_excp_d = 1'b1;
                conv_data_d = c_mode ? '0 : '1;
            end else begin
                conv_data_d = c_mode ? neg_mag : {1'b1, neg_mag[W-2:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
            out_excp_q  <= 1'b0;
        end else if (adv_out) begin
            out_valid_q <= c_valid;
            out_data_q  <= conv_data_d;
            out_mode_q  <= c_mode;
            out_excp_q  <= conv_excp_d;
        end
    end

    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_mode  = out_mode_q;
    assign s.out_excp  = out_excp_q;

`ifdef SGNMAG_EXCP_CNT_EN
    logic [CNT_W-1:0] excp_cnt_q;
    logic [CNT_W-1:0] excp_cnt_d;

    always_comb begin
        excp_cnt_d = excp_cnt_q;
        if (out_valid_q && s.out_ready && out_excp_q && (excp_cnt_q != '1)) begin
            excp_cnt_d = excp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            excp_cnt_q <= '0;
        end else begin
            excp_cnt_q <= excp_cnt_d;
        end
    end

    assign excp_cnt = excp_cnt_q;
`else
    generate
        if (CNT_W < 1) begin : g_no_excp_cnt
        end
    endgenerate
`endif

endmodule

// File: doc/sgnmag_conv_pipe.md
Name: sgnmag_conv_pipe

Overview:
- Parametrised, pipelined, bidirectional converter between two's-complement and sign-magnitude, with a valid/ready stream on each side.
- Generalises the lab's fixed 12-bit combinational two's-complement to sign-magnitude front end: any width, reverse conversion, per-sample mode, 1- or 2-stage latency, backpressure, and exception flagging.
- Sits between sample capture and the downstream encode stage of the lab datapath.

Parameters:
- W, 12, data width in bits including sign; legal range 2..32.
- PIPE, 2, number of register stages (1 or 2); equals latency in cycles with no stall.
- CNT_W, 8, width of the exception counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter accepts the sample this cycle.
- in_data  in  W  input sample.
- in_mode  in  1  0: two's-complement to sign-magnitude; 1: sign-magnitude to two's-complement.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  W  converted sample; in mode 0 the sign is bit W-1 and the magnitude is bits W-2:0.
- out_mode  out  1  mode carried with the sample.
- out_excp  out  1  exception flag carried with the sample.
- excp_cnt  out  CNT_W  exception count; present only with the optional feature.

Behaviour:
- Reset (synchronous, on clk edge with rst=1): out_valid=0, out_data=0, out_mode=0, out_excp=0, excp_cnt=0. All stage valid bits are cleared. Any data in flight is discarded and never emitted.
- Stall control:
  - advance = out_ready | ~out_valid.
  - When PIPE=2, also advance if stage 1 is empty.
  - in_ready = advance. This is combinational from out_ready; there is no skid buffer.
  - A transfer occurs on a cycle with in_valid & in_ready.
- Pipeline, PIPE=2:
  - Stage 1 registers in_data, in_mode and in_valid when it advances.
  - Stage 2 computes from the stage-1 values and registers out_data, out_mode, out_excp and out_valid.
  - With out_ready held at 1, a sample accepted on cycle N appears on cycle N+2.
- Pipeline, PIPE=1: compute from the input directly into the output registers; latency 1.
- While stalled (out_valid=1, out_ready=0), every output is held stable.
- Back-to-back throughput is 1 sample per cycle.
- Mode 0 (two's-complement to sign-magnitude), x = in_data:
  - x[W-1]=0: out = x, excp=0.
  - x[W-1]=1 and x[W-2:0]≠0: out = {1, (−x)[W-2:0]}, excp=0.
  - x = −2^(W-1): magnitude saturates. out = all ones, i.e. sign=1, magnitude=2^(W-1)−1. excp=1.
- Mode 1 (sign-magnitude to two's-complement), s = in_data[W-1], m = in_data[W-2:0]:
  - s=0: out = {0, m}, excp=0.
  - s=1 and m≠0: out = −m, W-bit two's-complement, excp=0.
  - s=1 and m=0 (negative zero): out = 0, excp=1.
- A bubble (in_valid=0 on an advancing cycle) propagates as out_valid=0. Data carried with a bubble is don't-care.
- Mode may change on every sample. There is no reconfiguration penalty.
- rst asserted at the same time as in_valid: the sample is not accepted and in_ready is ignored.

Optional Feature:
- Macro: SGNMAG_EXCP_CNT_EN.
- With the macro defined:
  - Port excp_cnt exists.
  - excp_cnt increments by 1 on each output handshake (out_valid & out_ready) where out_excp=1.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It clears on rst.
- Without the macro: the port and counter logic are absent. All other behaviour is identical.

Test Plan (W=12, PIPE=2 unless stated):
- Mode 0, out_ready=1, stream 0x005, 0xFFF, 0x800 on consecutive cycles -> outputs 0x005/excp0, 0x801/excp0, 0xFFF/excp1 on cycles +2, +3, +4.
- Mode 1, stream 0x805, 0x800, 0x7FF -> outputs 0xFFB/excp0, 0x000/excp1, 0x7FF/excp0. With SGNMAG_EXCP_CNT_EN defined, excp_cnt=1 afterwards.
- Alternate in_mode each cycle with in_data=0x801 -> outputs alternate 0xFFF (mode 0) and 0xFFF (mode 1). out_mode tracks the input mode, excp=0.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready=0 while the pipeline is full, outputs held stable, no sample lost or duplicated, order preserved.
- Reset mid-operation: pulse rst with 2 samples in flight -> out_valid=0 on the next cycle, the in-flight samples are never emitted, and the next accepted sample emerges 2 cycles later.
- PIPE=1, CNT_W=2, 5 consecutive 0x800 in mode 0 -> latency 1, and excp_cnt saturates at 3 when SGNMAG_EXCP_CNT_EN is defined.
